// File: rtl/csr_bank_pkg.sv
// Shared definitions for the CSR bank: register map, status/control bit
// positions, precision field layout and run-tracker state encoding.
package csr_bank_pkg;

  localparam int LOG_ALLOWED_PRECISIONS = 2;

  localparam int A_ARITHMETIC_PRECISION = 0;
  localparam int A_FP_MODE              = 1;
  localparam int A_STATUS               = 2;
  localparam int A_CONTROL              = 3;

  // PRECISION register: precision code, then chain, then fp/bfp flags
  localparam int PREC_CHAIN_BIT = LOG_ALLOWED_PRECISIONS;
  localparam int PREC_FP_BIT    = LOG_ALLOWED_PRECISIONS + 1;
  localparam int PREC_BFP_BIT   = LOG_ALLOWED_PRECISIONS + 2;

  localparam int ST_IDLE_BIT  = 0;
  localparam int ST_READY_BIT = 1;
  localparam int ST_DONE_BIT  = 2;
  localparam int ST_BUSY_BIT  = 3;

  localparam int CTL_START_BIT  = 0;
  localparam int CTL_GLB_EN_BIT = 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } run_state_t;

endpackage

// File: rtl/csr_bank_if.sv
// Host register port, control-unit CSR read port and start/done handshake
// between the host/CU side (master) and the CSR bank (slave).
interface csr_bank_if #(
  parameter int DATA_WIDTH_CSR   = 8,
  parameter int ADDRESS_SIZE_CSR = 32
);
  logic                        host_wr_en;
  logic                        host_rd_en;
  logic [ADDRESS_SIZE_CSR-1:0] host_addr;
  logic [DATA_WIDTH_CSR-1:0]   host_wdata;
  logic [DATA_WIDTH_CSR-1:0]   host_rdata;
  logic                        host_rvalid;
  logic                        host_wr_err;

  logic                        csr_ce;
  logic                        csr_we;
  logic [ADDRESS_SIZE_CSR-1:0] csr_address;
  logic                        csr_reset;
  logic [DATA_WIDTH_CSR-1:0]   csr_dout;

  logic                        cs_start;
  logic                        glb_enable;
  logic                        cs_ready;
  logic                        cs_done;
  logic                        cs_idle;

  modport master (
    output host_wr_en, host_rd_en, host_addr, host_wdata,
    input  host_rdata, host_rvalid, host_wr_err,
    output csr_ce, csr_we, csr_address, csr_reset,
    input  csr_dout,
    input  cs_start, glb_enable,
    output cs_ready, cs_done, cs_idle
  );

  modport slave (
    input  host_wr_en, host_rd_en, host_addr, host_wdata,
    output host_rdata, host_rvalid, host_wr_err,
    input  csr_ce, csr_we, csr_address, csr_reset,
    output csr_dout,
    output cs_start, glb_enable,
    input  cs_ready, cs_done, cs_idle
  );

endinterface

// File: rtl/csr_bank_run_tracker.sv
// Tracks whether the control unit is running, keeps sticky ready/done flags
// and requests the auto-clear of the start bit when a run completes.
module csr_bank_run_tracker
  import csr_bank_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic start,
  input  logic glb_enable,
  input  logic cs_idle,
  input  logic cs_ready,
  input  logic cs_done,
  input  logic status_rd_clr,
  output logic busy,
  output logic ready,
  output logic done,
  output logic start_clr
);

  run_state_t state_q, state_d;
  logic       idle_seen_q, idle_seen_d;
  logic       ready_q, done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idle_seen_q <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
    end else if (clr) begin
      state_q     <= S_IDLE;
      idle_seen_q <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_seen_q <= idle_seen_d;
      // A pulse coinciding with a clearing read wins, so no event is lost
      ready_q     <= (ready_q & ~status_rd_clr) | cs_ready;
      done_q      <= (done_q  & ~status_rd_clr) | cs_done;
    end
  end

  always_comb begin
    state_d     = state_q;
    idle_seen_d = 1'b0;
    start_clr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && glb_enable && cs_idle) state_d = S_RUN;
      end
      S_RUN: begin
        if (cs_done) begin
          state_d   = S_IDLE;
          start_clr = 1'b1;
        end else if (!start && cs_idle) begin
          // Start withdrawn and CU back in idle for two cycles: treat as abort
          if (idle_seen_q) state_d = S_IDLE;
          else             idle_seen_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy  = (state_q == S_RUN);
  assign ready = ready_q;
  assign done  = done_q;

endmodule

// File: rtl/csr_bank.sv
// Control/status register bank: host register port, CU CSR read port and the
// start/ready/done/idle handshake towards the control unit.
module csr_bank
  import csr_bank_pkg::*;
#(
  parameter int DATA_WIDTH_CSR   = 8,
  parameter int ADDRESS_SIZE_CSR = 32,
  parameter int NUM_REGS         = 4
) (
  input logic       clk,
  input logic       reset,
  csr_bank_if.slave bus
);

  localparam int DW = DATA_WIDTH_CSR;
  localparam int AW = ADDRESS_SIZE_CSR;

  logic [DW-1:0] prec_q, fpm_q, ctrl_q;
  logic [DW-1:0] host_rdata_q, csr_dout_q;
  logic          host_rvalid_q, host_wr_err_q;

  logic          busy, ready, done, start_clr;
  logic [DW-1:0] status_w;
  logic [DW-1:0] view [4];
  logic [DW-1:0] host_rd_val, cu_rd_val;
  logic          host_cfg_addr, wr_ok, wr_err, status_rd_clr;

  function automatic logic mapped(input logic [AW-1:0] a);
    return (a < AW'(NUM_REGS)) && (a < AW'(4));
  endfunction

  always_comb begin
    status_w               = '0;
    status_w[ST_IDLE_BIT]  = bus.cs_idle;
    status_w[ST_READY_BIT] = ready;
    status_w[ST_DONE_BIT]  = done;
    status_w[ST_BUSY_BIT]  = busy;
  end

  assign view[A_ARITHMETIC_PRECISION] = prec_q;
  assign view[A_FP_MODE]              = fpm_q;
  assign view[A_STATUS]               = status_w;
  assign view[A_CONTROL]              = ctrl_q;

  assign host_rd_val = mapped(bus.host_addr)   ? view[bus.host_addr[1:0]]   : '0;
  assign cu_rd_val   = mapped(bus.csr_address) ? view[bus.csr_address[1:0]] : '0;

  // Precision/FP mode are frozen while a run is in progress
  assign host_cfg_addr = (bus.host_addr == AW'(A_ARITHMETIC_PRECISION)) ||
                         (bus.host_addr == AW'(A_FP_MODE));
  assign wr_ok  = bus.host_wr_en && mapped(bus.host_addr) &&
                  (bus.host_addr != AW'(A_STATUS)) && !(busy && host_cfg_addr);
  assign wr_err = bus.host_wr_en && !wr_ok;

  // Only host reads clear sticky flags; CU polling leaves them for the host
  assign status_rd_clr = bus.host_rd_en && (bus.host_addr == AW'(A_STATUS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prec_q        <= '0;
      fpm_q         <= '0;
      ctrl_q        <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      host_wr_err_q <= 1'b0;
      csr_dout_q    <= '0;
    end else if (bus.csr_reset) begin
      prec_q        <= '0;
      fpm_q         <= '0;
      ctrl_q        <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      host_wr_err_q <= 1'b0;
      csr_dout_q    <= '0;
    end else begin
      host_rvalid_q <= bus.host_rd_en;
      host_wr_err_q <= wr_err;
      if (bus.host_rd_en) host_rdata_q <= host_rd_val;
      if (bus.csr_ce)     csr_dout_q   <= cu_rd_val;
      if (wr_ok) begin
        case (bus.host_addr[1:0])
          2'(A_ARITHMETIC_PRECISION): prec_q <= bus.host_wdata;
          2'(A_FP_MODE):              fpm_q  <= bus.host_wdata;
          default:                    ctrl_q <= bus.host_wdata;
        endcase
      end
      if (start_clr) ctrl_q[CTL_START_BIT] <= 1'b0;
    end
  end

  csr_bank_run_tracker u_run_tracker (
    .clk           (clk),
    .reset         (reset),
    .clr           (bus.csr_reset),
    .start         (ctrl_q[CTL_START_BIT]),
    .glb_enable    (ctrl_q[CTL_GLB_EN_BIT]),
    .cs_idle       (bus.cs_idle),
    .cs_ready      (bus.cs_ready),
    .cs_done       (bus.cs_done),
    .status_rd_clr (status_rd_clr),
    .busy          (busy),
    .ready         (ready),
    .done          (done),
    .start_clr     (start_clr)
  );

  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_wr_err = host_wr_err_q;
  assign bus.csr_dout    = csr_dout_q;
  assign bus.cs_start    = ctrl_q[CTL_START_BIT];
  assign bus.glb_enable  = ctrl_q[CTL_GLB_EN_BIT];

endmodule

// File: tb/tb_csr_bank.sv
// Bench for csr_bank: directed vector table, async-reset sequence and a
// randomized run against a register-map-level reference model.
module tb_csr_bank;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  csr_bank_if #(.DATA_WIDTH_CSR(8), .ADDRESS_SIZE_CSR(32)) bus ();

  csr_bank #(.DATA_WIDTH_CSR(8), .ADDRESS_SIZE_CSR(32), .NUM_REGS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          wr, rd;
    logic [31:0] ha;
    logic [7:0]  wd;
    bit          ce, we;
    logic [31:0] ca;
    bit          crst, rdy, dn, idl;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Reference model: register contents, run flag and sticky flags
  logic [7:0] m_reg [4];
  bit         m_busy, m_ready, m_done, m_rv, m_err;
  int         m_idle_run;
  logic [7:0] m_rdata, m_dout;

  function automatic vec_t v(bit wr, bit rd, logic [31:0] ha, logic [7:0] wd,
                             bit ce, bit we, logic [31:0] ca, bit crst, bit rdy,
                             bit dn, bit idl, bit rv, logic [7:0] rdt, bit err,
                             logic [7:0] dout, bit st, bit gl);
    vec_t r;
    r.wr = wr; r.rd = rd; r.ha = ha; r.wd = wd; r.ce = ce; r.we = we; r.ca = ca;
    r.crst = crst; r.rdy = rdy; r.dn = dn; r.idl = idl;
    r.exp = {rv, rdt, err, dout, st, gl};
    return r;
  endfunction

  function automatic logic [19:0] dut_out();
    return {bus.host_rvalid, bus.host_rdata, bus.host_wr_err, bus.csr_dout,
            bus.cs_start, bus.glb_enable};
  endfunction

  function automatic logic [19:0] model_out();
    return {m_rv, m_rdata, m_err, m_dout, m_reg[3][0], m_reg[3][1]};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {rv,rdata,err,dout,start,glb}=%h required %h", name, act, exp);
    end
  endtask

  task automatic drive(bit wr, bit rd, logic [31:0] ha, logic [7:0] wd, bit ce, bit we,
                       logic [31:0] ca, bit crst, bit rdy, bit dn, bit idl);
    bus.host_wr_en = wr;  bus.host_rd_en = rd;  bus.host_addr = ha;  bus.host_wdata = wd;
    bus.csr_ce = ce;  bus.csr_we = we;  bus.csr_address = ca;  bus.csr_reset = crst;
    bus.cs_ready = rdy;  bus.cs_done = dn;  bus.cs_idle = idl;
  endtask

  task automatic model_clear();
    m_reg = '{default: 8'h00};
    m_busy = 0; m_ready = 0; m_done = 0; m_rv = 0; m_err = 0;
    m_idle_run = 0; m_rdata = 8'h00; m_dout = 8'h00;
  endtask

  function automatic logic [7:0] m_read(logic [31:0] a);
    if (a == 32'd2) return {4'b0, m_busy, m_done, m_ready, bus.cs_idle};
    if (a < 32'd4)  return m_reg[a[1:0]];
    return 8'h00;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    logic [7:0] hr, cr, old_ctrl;
    bit         old_busy, wr_ok;
    if (bus.csr_reset) begin
      model_clear();
      return;
    end
    hr = m_read(bus.host_addr);
    cr = m_read(bus.csr_address);
    old_busy = m_busy;
    old_ctrl = m_reg[3];
    m_rv = bus.host_rd_en;
    if (bus.host_rd_en) m_rdata = hr;
    if (bus.csr_ce) m_dout = cr;
    wr_ok = bus.host_wr_en &&
            (bus.host_addr == 0 || bus.host_addr == 1 || bus.host_addr == 3) &&
            !(old_busy && bus.host_addr < 2);
    m_err = bus.host_wr_en && !wr_ok;
    if (wr_ok) m_reg[bus.host_addr[1:0]] = bus.host_wdata;
    if (!old_busy) begin
      if (old_ctrl[0] && old_ctrl[1] && bus.cs_idle) begin
        m_busy = 1;
        m_idle_run = 0;
      end
    end else if (bus.cs_done) begin
      m_busy = 0;
      m_reg[3][0] = 1'b0;
    end else if (!old_ctrl[0] && bus.cs_idle) begin
      m_idle_run++;
      if (m_idle_run >= 2) m_busy = 0;
    end else begin
      m_idle_run = 0;
    end
    m_ready = (m_ready && !(bus.host_rd_en && bus.host_addr == 2)) || bus.cs_ready;
    m_done  = (m_done  && !(bus.host_rd_en && bus.host_addr == 2)) || bus.cs_done;
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] raddr();
    if ($urandom % 8 == 0) return $urandom;
    return 32'($urandom_range(0, 4));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();
    check("reset_state", dut_out(), 20'h0);

    //        wr rd ha  wd     ce we ca crst rdy dn idl | rv rdata err dout  st gl
    tbl.push_back(v(1,0,0,8'h05, 0,0,0, 0,0,0,1, 0,8'h00,0,8'h00,0,0));
    tbl.push_back(v(0,0,0,8'h00, 1,0,0, 0,0,0,1, 0,8'h00,0,8'h05,0,0));
    tbl.push_back(v(0,0,0,8'h00, 1,0,0, 0,0,0,1, 0,8'h00,0,8'h05,0,0));
    tbl.push_back(v(0,0,0,8'h00, 1,0,0, 0,0,0,1, 0,8'h00,0,8'h05,0,0));
    tbl.push_back(v(0,1,0,8'h00, 0,0,0, 0,0,0,1, 1,8'h05,0,8'h05,0,0));
    tbl.push_back(v(0,0,0,8'h00, 0,0,0, 0,0,0,1, 0,8'h05,0,8'h05,0,0));
    tbl.push_back(v(1,0,3,8'h03, 0,0,0, 0,0,0,1, 0,8'h05,0,8'h05,1,1));
    tbl.push_back(v(0,0,0,8'h00, 0,0,0, 0,0,0,1, 0,8'h05,0,8'h05,1,1));
    tbl.push_back(v(1,0,0,8'h07, 0,0,0, 0,0,0,1, 0,8'h05,1,8'h05,1,1));
    tbl.push_back(v(0,1,0,8'h00, 0,0,0, 0,0,0,1, 1,8'h05,0,8'h05,1,1));
    tbl.push_back(v(0,1,2,8'h00, 0,0,0, 0,0,0,1, 1,8'h09,0,8'h05,1,1));
    tbl.push_back(v(0,0,0,8'h00, 0,0,0, 0,0,1,1, 0,8'h09,0,8'h05,0,1));
    tbl.push_back(v(0,1,3,8'h00, 0,0,0, 0,0,0,1, 1,8'h02,0,8'h05,0,1));
    tbl.push_back(v(0,1,2,8'h00, 0,0,0, 0,0,0,1, 1,8'h05,0,8'h05,0,1));
    tbl.push_back(v(0,1,2,8'h00, 0,0,0, 0,0,1,1, 1,8'h01,0,8'h05,0,1));
    tbl.push_back(v(0,1,2,8'h00, 0,0,0, 0,0,0,1, 1,8'h05,0,8'h05,0,1));
    tbl.push_back(v(0,1,2,8'h00, 0,0,0, 0,0,0,1, 1,8'h01,0,8'h05,0,1));
    tbl.push_back(v(1,0,9,8'h55, 0,0,0, 0,0,0,1, 0,8'h01,1,8'h05,0,1));
    tbl.push_back(v(1,0,2,8'hFF, 0,0,0, 0,0,0,1, 0,8'h01,1,8'h05,0,1));
    tbl.push_back(v(0,1,9,8'h00, 0,0,0, 0,0,0,1, 1,8'h00,0,8'h05,0,1));
    tbl.push_back(v(0,0,0,8'h00, 1,1,0, 0,0,0,1, 0,8'h00,0,8'h05,0,1));
    tbl.push_back(v(1,1,1,8'h3C, 0,0,0, 0,0,0,1, 1,8'h00,0,8'h05,0,1));
    tbl.push_back(v(0,1,1,8'h00, 0,0,0, 0,0,0,1, 1,8'h3C,0,8'h05,0,1));
    tbl.push_back(v(0,0,0,8'h00, 0,0,0, 0,1,0,1, 0,8'h3C,0,8'h05,0,1));
    tbl.push_back(v(0,0,0,8'h00, 1,0,2, 0,0,0,1, 0,8'h3C,0,8'h03,0,1));
    tbl.push_back(v(0,0,0,8'h00, 1,0,2, 0,0,0,1, 0,8'h3C,0,8'h03,0,1));
    tbl.push_back(v(1,0,3,8'h03, 0,0,0, 0,0,0,1, 0,8'h3C,0,8'h03,1,1));
    tbl.push_back(v(0,0,0,8'h00, 0,0,0, 0,0,0,1, 0,8'h3C,0,8'h03,1,1));
    tbl.push_back(v(0,0,0,8'h00, 1,0,2, 0,0,0,1, 0,8'h3C,0,8'h0B,1,1));
    tbl.push_back(v(0,0,0,8'h00, 0,0,0, 1,0,0,1, 0,8'h00,0,8'h00,0,0));
    tbl.push_back(v(0,1,0,8'h00, 1,0,2, 0,0,0,1, 1,8'h00,0,8'h01,0,0));
    tbl.push_back(v(1,0,3,8'h03, 0,0,0, 0,0,0,1, 0,8'h00,0,8'h01,1,1));
    tbl.push_back(v(0,0,0,8'h00, 0,0,0, 0,0,0,1, 0,8'h00,0,8'h01,1,1));
    tbl.push_back(v(0,0,0,8'h00, 0,0,0, 0,0,0,0, 0,8'h00,0,8'h01,1,1));
    tbl.push_back(v(1,0,3,8'h02, 0,0,0, 0,0,0,0, 0,8'h00,0,8'h01,0,1));
    tbl.push_back(v(0,0,0,8'h00, 0,0,0, 0,0,0,1, 0,8'h00,0,8'h01,0,1));
    tbl.push_back(v(0,1,2,8'h00, 0,0,0, 0,0,0,1, 1,8'h09,0,8'h01,0,1));
    tbl.push_back(v(0,1,2,8'h00, 0,0,0, 0,0,0,1, 1,8'h01,0,8'h01,0,1));
    tbl.push_back(v(1,0,3,8'h03, 0,0,0, 0,0,0,1, 0,8'h01,0,8'h01,1,1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].wr, tbl[i].rd, tbl[i].ha, tbl[i].wd, tbl[i].ce, tbl[i].we,
            tbl[i].ca, tbl[i].crst, tbl[i].rdy, tbl[i].dn, tbl[i].idl);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
    end

    // Asynchronous reset mid-transaction with CONTROL=0x03
    drive(0, 1, 3, 8'h00, 1, 0, 3, 0, 0, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst", dut_out(), 20'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    check("post_rst", dut_out(), 20'h0);
    drive(0, 0, 0, 8'h00, 1, 0, 3, 0, 0, 0, 1);
    @(posedge clk); #1;
    check("ctrl_cleared", dut_out(), 20'h0);

    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom % 10) < 3, ($urandom % 10) < 3, raddr(), 8'($urandom),
            ($urandom % 2) == 0, ($urandom % 4) == 0, raddr(), ($urandom % 60) == 0,
            ($urandom % 10) == 0, ($urandom % 10) == 0, ($urandom % 10) < 7);
      model_step();
      @(posedge clk); #1;
      check($sformatf("rand%0d", c), dut_out(), model_out());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csr_bank.md
Name: csr_bank

Overview:
- Control/status register bank that answers the control unit's CSR read port (csr_ce/csr_we/csr_address/csr_reset -> csr_dout).
- Also the PS-facing end of the start/ready/done/idle handshake.
- The host programs precision/FP mode through a simple register port and raises start.
- The block drives cs_start/glb_enable to the control unit and captures cs_ready/cs_done/cs_idle into sticky status.

Parameters:
- DATA_WIDTH_CSR, 8, register and data width.
- ADDRESS_SIZE_CSR, 32, address width of both ports.
- NUM_REGS, 4, implemented registers; addresses >= NUM_REGS are unmapped.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- host_wr_en  in  1  host write strobe
- host_rd_en  in  1  host read strobe
- host_addr  in  ADDRESS_SIZE_CSR  host address
- host_wdata  in  DATA_WIDTH_CSR  host write data
- host_rdata  out  DATA_WIDTH_CSR  host read data
- host_rvalid  out  1  one-cycle pulse, host_rdata valid
- host_wr_err  out  1  one-cycle pulse, host write dropped
- csr_ce  in  1  CU read enable
- csr_we  in  1  CU write enable (CU writes not supported, dropped)
- csr_address  in  ADDRESS_SIZE_CSR  CU read address
- csr_reset  in  1  synchronous clear request from CU
- csr_dout  out  DATA_WIDTH_CSR  CU read data
- cs_start  out  1  start level to CU
- glb_enable  out  1  global enable to CU
- cs_ready  in  1  CU ready pulse
- cs_done  in  1  CU done pulse
- cs_idle  in  1  CU idle level

Behaviour:
- Address map:
  - 0 PRECISION (RW): bits[LOG_ALLOWED_PRECISIONS-1:0] precision, next bit chain, next two bits fp/bfp.
  - 1 FP_MODE (RW).
  - 2 STATUS (RO): bit0 idle (live), bit1 ready (sticky), bit2 done (sticky), bit3 busy (live).
  - 3 CONTROL (RW): bit0 start, bit1 glb_enable.
- Reset (async) and csr_reset (sync, next edge) clear every register and output to 0. Reset has priority over csr_reset; csr_reset has priority over all writes.
- CU read: csr_ce=1 with csr_address sampled at edge N; csr_dout is registered and valid from N+1. csr_dout holds its value while csr_ce=0. Unmapped address returns 0. csr_we=1 is ignored (read still performed).
- CU read timing: the CU holds csr_ce high for three cycles and samples dout in the third. A single-cycle registered read satisfies this.
- Host read: host_rd_en at N -> host_rdata valid and host_rvalid=1 at N+1. Unmapped address returns 0.
- Reading STATUS clears ready/done (clear-on-read). If a cs_done/cs_ready pulse arrives in the same cycle as that read: the read returns the old value and the bit ends set (set wins).
- Host write: takes effect at the next edge. host_wr_err pulses and the write is dropped when:
  - the address is unmapped or STATUS;
  - the address is 0/1 while busy=1 (config locked during a run).
- Simultaneous host_rd_en and host_wr_en: both proceed. The read returns the pre-write value.
- cs_start = CONTROL.bit0; glb_enable = CONTROL.bit1; both are registered.
- Run tracker, 2 states:
  - IDLE -> RUN on cs_start=1 && glb_enable=1 && cs_idle=1.
  - RUN -> IDLE on cs_done=1. On that edge CONTROL.bit0 clears (cs_start drops the cycle after done). done sets.
  - busy=1 in RUN.
- Host clearing start mid-run: RUN is kept until cs_done or until cs_idle returns to 1 for 2 consecutive cycles (CU aborted to idle); then -> IDLE with no done set.
- cs_ready pulse sets ready in any state.

Decomposition:
- Shared package/header (extends csr_definition.vh):
  - register addresses A_ARITHMETIC_PRECISION=0, A_FP_MODE=1, A_STATUS=2, A_CONTROL=3;
  - status/control bit indices;
  - state encodings S_IDLE/S_RUN.
- Precision field widths come from precision_def.vh.
- One sub-module is natural: csr_run_tracker (run state, busy, sticky ready/done, start auto-clear). The register file and both read ports stay in csr_bank.

Test Plan:
- Reset mid-transaction with CONTROL=0x03 -> all outputs 0 immediately; cs_start=0, csr_dout=0.
- Host writes addr0=0x05, then CU csr_ce=1, addr0 for 3 cycles -> csr_dout=0x05 from the 2nd cycle on; host read of addr0 -> host_rvalid at N+1, host_rdata=0x05.
- Host writes CONTROL=0x03 with cs_idle=1 -> busy=1; host write addr0=0x07 -> host_wr_err pulse, addr0 stays 0x05; cs_done pulse -> CONTROL reads 0x02, STATUS bit2=1, busy=0.
- Host reads STATUS in the same cycle as a cs_done pulse -> returned bit2 = old value (0); the next STATUS read returns bit2=1; the read after that returns bit2=0.
- Host writes addr 9 and addr 2 -> two host_wr_err pulses; reads of addr 9 -> 0x00; CU csr_we=1 on addr0 -> contents unchanged.
- csr_reset pulse in RUN -> next cycle all registers 0, run state IDLE, cs_start=0.
